calc_key_arbiter: RTL and testbench

- Merges key events from two sources, the matrix keypad scanner and the UART command decoder, into the single btn_valid/btn_char stream that drives the calculator FSM.
- Each source has its own small FIFO. Sources are served round-robin, with an enforced idle gap between issued keys.
- Illegal codes are filtered out. A 'C' from either source has priority and flushes all pending keys.

---
 rtl/calc_key_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_calc_key_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_arbiter.sv
// calc_key_arbiter
// Merges key events from the keypad scanner and the UART command decoder
// into the single btn_valid/btn_char strobe stream for the calculator FSM.
// Each source feeds its own FIFO. The sources are served round-robin, and
// a minimum idle gap is kept between issued keys. Illegal codes are dropped
// and counted. A 'C' from either source flushes all pending keys and is
// issued ahead of everything else.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   kp_valid/kp_char      keypad key offer;   kp_ready = keypad FIFO not full
//   ur_valid/ur_char      UART key offer;     ur_ready = UART FIFO not full
//   hold                  downstream stall, no issue while high
//   btn_valid/btn_char    one-cycle key strobe and its code (registered)
//   grant_src             source of the issued key, 0 = keypad, 1 = UART
//   drop_cnt              saturating count of filtered illegal codes
//   busy                  clear pending, any FIFO non-empty, or gap running
module calc_key_arbiter #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kp_valid,
    input  logic [7:0] kp_char,
    output logic       kp_ready,
    input  logic       ur_valid,
    input  logic [7:0] ur_char,
    output logic       ur_ready,
    input  logic       hold,
    output logic       btn_valid,
    output logic [7:0] btn_char,
    output logic       grant_src,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW    = AW + 1;
    localparam logic [CW-1:0]   FULL  = CW'(DEPTH);
    localparam logic [3:0]      GAP_L = 4'(GAP);
    localparam logic [7:0]      CHR_C = 8'h43;

    // Legal key set: digits, + - * =, C and backspace.
    function automatic logic is_legal(input logic [7:0] c);
        logic ok;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            ok = 1'b1;
        end else begin
            case (c)
                8'h2A, 8'h2B, 8'h2D, 8'h3D, 8'h43, 8'h08: ok = 1'b1;
                default:                                  ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Source-indexed views of the inputs (0 = keypad, 1 = UART).
    logic [1:0] in_valid_s;
    logic [7:0] in_char_s [2];

    assign in_valid_s   = {ur_valid, kp_valid};
    assign in_char_s[0] = kp_char;
    assign in_char_s[1] = ur_char;

    // Registered state.
    logic [7:0]    mem_q [2][DEPTH];
    logic [AW-1:0] wp_q  [2];
    logic [AW-1:0] rp_q  [2];
    logic [CW-1:0] cnt_q [2];
    logic          pclr_q;
    logic          clr_src_q;
    logic          last_q;
    logic [3:0]    gap_q;
    logic [7:0]    drop_q;
    logic          btn_valid_q;
    logic [7:0]    btn_char_q;
    logic          grant_q;
    logic          busy_q;

    // Next-state values.
    logic [AW-1:0] wp_d  [2];
    logic [AW-1:0] rp_d  [2];
    logic [CW-1:0] cnt_d [2];
    logic          pclr_d;
    logic          clr_src_d;
    logic          last_d;
    logic [3:0]    gap_d;
    logic [7:0]    drop_d;
    logic [7:0]    btn_char_d;
    logic          grant_d;
    logic          busy_d;

    // Per-cycle decode.
    logic [1:0] ready_s;
    logic [1:0] acc_s;
    logic [1:0] isc_s;
    logic [1:0] ill_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic [1:0] nonempty_s;
    logic       any_c_s;
    logic       issue_s;
    logic       pick_s;
    logic [8:0] drop_sum_s;

    // Accept/filter decode, arbitration and next-state computation.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ready_s[s]    = (cnt_q[s] != FULL);
            acc_s[s]      = in_valid_s[s] && ready_s[s];
            isc_s[s]      = acc_s[s] && (in_char_s[s] == CHR_C);
            ill_s[s]      = acc_s[s] && !is_legal(in_char_s[s]);
            nonempty_s[s] = (cnt_q[s] != {CW{1'b0}});
        end
        any_c_s = |isc_s;
        // A 'C' on this edge also discards a legal key from the other source.
        for (int s = 0; s < 2; s++) begin
            push_s[s] = acc_s[s] && !ill_s[s] && !any_c_s;
        end

        issue_s = (gap_q == 4'd0) && !hold && (pclr_q || (|nonempty_s));

        if (nonempty_s[0] && nonempty_s[1]) begin
            pick_s = ~last_q;
        end else if (nonempty_s[0]) begin
            pick_s = 1'b0;
        end else begin
            pick_s = 1'b1;
        end

        pop_s[0] = issue_s && !pclr_q && (pick_s == 1'b0);
        pop_s[1] = issue_s && !pclr_q && (pick_s == 1'b1);

        // FIFO bookkeeping; a flush wins over any push/pop on the same edge.
        for (int s = 0; s < 2; s++) begin
            if (any_c_s) begin
                cnt_d[s] = {CW{1'b0}};
                wp_d[s]  = {AW{1'b0}};
                rp_d[s]  = {AW{1'b0}};
            end else begin
                cnt_d[s] = cnt_q[s] + CW'(push_s[s]) - CW'(pop_s[s]);
                wp_d[s]  = push_s[s] ? (wp_q[s] + AW'(1)) : wp_q[s];
                rp_d[s]  = pop_s[s]  ? (rp_q[s] + AW'(1)) : rp_q[s];
            end
        end

        // A new 'C' keeps one clear pending even if one is issued now.
        if (any_c_s) begin
            pclr_d    = 1'b1;
            clr_src_d = isc_s[0] ? 1'b0 : 1'b1;
        end else if (issue_s && pclr_q) begin
            pclr_d    = 1'b0;
            clr_src_d = clr_src_q;
        end else begin
            pclr_d    = pclr_q;
            clr_src_d = clr_src_q;
        end

        if (|pop_s) begin
            last_d = pick_s;
        end else begin
            last_d = last_q;
        end

        if (issue_s) begin
            gap_d = GAP_L;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end else begin
            gap_d = 4'd0;
        end

        drop_sum_s = {1'b0, drop_q} + 9'(ill_s[0]) + 9'(ill_s[1]);
        if (drop_sum_s[8]) begin
            drop_d = 8'hFF;
        end else begin
            drop_d = drop_sum_s[7:0];
        end

        // The issued key uses the pre-flush head of the granted FIFO.
        if (issue_s && pclr_q) begin
            btn_char_d = CHR_C;
            grant_d    = clr_src_q;
        end else if (issue_s) begin
            btn_char_d = mem_q[pick_s][rp_q[pick_s]];
            grant_d    = pick_s;
        end else begin
            btn_char_d = 8'h00;
            grant_d    = 1'b0;
        end

        busy_d = pclr_d || (cnt_d[0] != {CW{1'b0}}) ||
                 (cnt_d[1] != {CW{1'b0}}) || (gap_d != 4'd0);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                wp_q[s]  <= {AW{1'b0}};
                rp_q[s]  <= {AW{1'b0}};
                cnt_q[s] <= {CW{1'b0}};
            end
            pclr_q      <= 1'b0;
            clr_src_q   <= 1'b0;
            last_q      <= 1'b1;
            gap_q       <= 4'd0;
            drop_q      <= 8'h00;
            btn_valid_q <= 1'b0;
            btn_char_q  <= 8'h00;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wp_q[s]  <= wp_d[s];
                rp_q[s]  <= rp_d[s];
                cnt_q[s] <= cnt_d[s];
            end
            pclr_q      <= pclr_d;
            clr_src_q   <= clr_src_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            drop_q      <= drop_d;
            btn_valid_q <= issue_s;
            btn_char_q  <= btn_char_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[s][i] <= 8'h00;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push_s[s]) begin
                    mem_q[s][wp_q[s]] <= in_char_s[s];
                end
            end
        end
    end

    assign kp_ready  = ready_s[0];
    assign ur_ready  = ready_s[1];
    assign btn_valid = btn_valid_q;
    assign btn_char  = btn_char_q;
    assign grant_src = grant_q;
    assign drop_cnt  = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_calc_key_arbiter.sv
// Directed bench for calc_key_arbiter with DEPTH=4, GAP=2.
module tb_calc_key_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kp_valid;
    logic [7:0] kp_char;
    logic       kp_ready;
    logic       ur_valid;
    logic [7:0] ur_char;
    logic       ur_ready;
    logic       hold;
    logic       btn_valid;
    logic [7:0] btn_char;
    logic       grant_src;
    logic [7:0] drop_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    calc_key_arbiter #(.DEPTH(4), .GAP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kp_valid  (kp_valid),
        .kp_char   (kp_char),
        .kp_ready  (kp_ready),
        .ur_valid  (ur_valid),
        .ur_char   (ur_char),
        .ur_ready  (ur_ready),
        .hold      (hold),
        .btn_valid (btn_valid),
        .btn_char  (btn_char),
        .grant_src (grant_src),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step until btn_valid is seen or the budget runs out; n = cycles stepped.
    task automatic wait_pulse(input int max_cyc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((btn_valid !== 1'b1) && (n < max_cyc));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        kp_valid = 1'b0; kp_char = 8'h00;
        ur_valid = 1'b0; ur_char = 8'h00;
        hold = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Expected pulse pattern for test 1, one entry per cycle after edge k+1.
    logic       t1_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] t1_c [7] = '{8'h31, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00, 8'h2B};
    logic [7:0] t2_c [4] = '{8'h31, 8'h37, 8'h32, 8'h38};
    logic       t2_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;

        // ---- Reset state ----
        rst_n = 1'b0;
        kp_valid = 1'b0; kp_char = 8'h00;
        ur_valid = 1'b0; ur_char = 8'h00;
        hold = 1'b0;
        step();
        check("rst_btn_valid", 32'(btn_valid), 32'd0);
        check("rst_btn_char",  32'(btn_char),  32'd0);
        check("rst_grant",     32'(grant_src), 32'd0);
        check("rst_drop",      32'(drop_cnt),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_kp_ready",  32'(kp_ready),  32'd1);
        check("rst_ur_ready",  32'(ur_ready),  32'd1);
        rst_n = 1'b1;
        step();

        // ---- Test 1: keypad 1,2,+ on consecutive edges ----
        kp_valid = 1'b1; kp_char = 8'h31;
        step();                                   // edge k
        check("t1_no_pulse_at_k", 32'(btn_valid), 32'd0);
        kp_char = 8'h32;
        for (int i = 0; i < 7; i++) begin
            step();                               // edges k+1 .. k+7
            if (i == 0) kp_char = 8'h2B;
            if (i == 1) kp_valid = 1'b0;
            check($sformatf("t1_valid_%0d", i), 32'(btn_valid), 32'(t1_v[i]));
            check($sformatf("t1_char_%0d", i),  32'(btn_char),  32'(t1_c[i]));
            check($sformatf("t1_grant_%0d", i), 32'(grant_src), 32'd0);
        end

        // ---- Test 2: both sources loaded, round-robin order ----
        do_reset();
        kp_valid = 1'b1; kp_char = 8'h31;
        ur_valid = 1'b1; ur_char = 8'h37;
        step();
        kp_char = 8'h32; ur_char = 8'h38;
        step();
        kp_valid = 1'b0; ur_valid = 1'b0;
        check("t2_valid_0", 32'(btn_valid), 32'd1);
        check("t2_char_0",  32'(btn_char),  32'(t2_c[0]));
        check("t2_src_0",   32'(grant_src), 32'(t2_s[0]));
        for (int i = 1; i < 4; i++) begin
            wait_pulse(10, n);
            check($sformatf("t2_valid_%0d", i),   32'(btn_valid), 32'd1);
            check($sformatf("t2_spacing_%0d", i), 32'(n),         32'd3);
            check($sformatf("t2_char_%0d", i),    32'(btn_char),  32'(t2_c[i]));
            check($sformatf("t2_src_%0d", i),     32'(grant_src), 32'(t2_s[i]));
        end

        // ---- Test 3: fill keypad FIFO under hold, then drain ----
        do_reset();
        hold = 1'b1;
        kp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kp_char = 8'(8'h31 + i);
            check($sformatf("t3_ready_before_%0d", i), 32'(kp_ready), 32'd1);
            step();
        end
        kp_char = 8'h35;
        check("t3_ready_full", 32'(kp_ready), 32'd0);
        check("t3_ur_ready",   32'(ur_ready), 32'd1);
        step();
        kp_valid = 1'b0;
        check("t3_ready_still_full", 32'(kp_ready),  32'd0);
        check("t3_no_issue_hold",    32'(btn_valid), 32'd0);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(10, n);
            check($sformatf("t3_valid_%0d", i),   32'(btn_valid), 32'd1);
            check($sformatf("t3_spacing_%0d", i), 32'(n), (i == 0) ? 32'd1 : 32'd3);
            check($sformatf("t3_char_%0d", i),    32'(btn_char),  32'(8'h31 + i));
        end
        wait_pulse(10, n);
        check("t3_no_fifth", 32'(btn_valid), 32'd0);
        check("t3_idle",     32'(busy),      32'd0);

        // ---- Test 4: 'C' flush with one key already issuing ----
        do_reset();
        hold = 1'b1;
        kp_valid = 1'b1; kp_char = 8'h33;
        ur_valid = 1'b1; ur_char = 8'h35;
        step();
        kp_char = 8'h34; ur_valid = 1'b0;
        step();
        kp_valid = 1'b0;
        step();
        hold = 1'b0;
        ur_valid = 1'b1; ur_char = 8'h43;
        step();                                   // issue '3' and accept 'C'
        ur_valid = 1'b0;
        check("t4_pre_valid", 32'(btn_valid), 32'd1);
        check("t4_pre_char",  32'(btn_char),  32'h33);
        check("t4_pre_src",   32'(grant_src), 32'd0);
        wait_pulse(10, n);
        check("t4_c_valid",   32'(btn_valid), 32'd1);
        check("t4_c_spacing", 32'(n),         32'd3);
        check("t4_c_char",    32'(btn_char),  32'h43);
        check("t4_c_src",     32'(grant_src), 32'd1);
        check("t4_busy_0",    32'(busy),      32'd1);
        step();
        check("t4_busy_1",    32'(busy),      32'd1);
        step();
        check("t4_busy_fall", 32'(busy),      32'd0);
        wait_pulse(10, n);
        check("t4_no_stale",  32'(btn_valid), 32'd0);

        // ---- Test 5: illegal codes and drop counter saturation ----
        do_reset();
        kp_valid = 1'b1; kp_char = 8'h41;
        ur_valid = 1'b1; ur_char = 8'h20;
        step();
        kp_valid = 1'b0; ur_valid = 1'b0;
        check("t5_drop_2", 32'(drop_cnt), 32'd2);
        wait_pulse(6, n);
        check("t5_no_issue", 32'(btn_valid), 32'd0);
        check("t5_not_busy", 32'(busy),      32'd0);
        kp_valid = 1'b1; kp_char = 8'h41;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 99) check("t5_drop_102", 32'(drop_cnt), 32'd102);
        end
        kp_valid = 1'b0;
        check("t5_drop_sat", 32'(drop_cnt), 32'd255);
        step();
        check("t5_drop_hold", 32'(drop_cnt), 32'd255);

        // ---- Test 6: asynchronous reset mid-gap with a queued key ----
        do_reset();
        kp_valid = 1'b1; kp_char = 8'h31;
        step();
        kp_char = 8'h32;
        step();
        kp_valid = 1'b0;
        check("t6_pulse_before", 32'(btn_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(btn_valid), 32'd0);
        check("t6_rst_char",  32'(btn_char),  32'd0);
        check("t6_rst_busy",  32'(busy),      32'd0);
        #2;
        rst_n = 1'b1;
        wait_pulse(10, n);
        check("t6_no_stale", 32'(btn_valid), 32'd0);
        check("t6_idle",     32'(busy),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
